// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory address and
// registers each fetched word with its PC for decode; handles stall, branch flush and range faults.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [31:0] TEXT_LIMIT = 32'h0040_0400
) (
  input  logic        i_clock,
  input  logic        i_clear,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_instr_out,
  output logic [31:0] o_pc_out,
  output logic        o_instr_valid,
  output logic        o_fault,
  output logic [15:0] o_fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FAULT} state_t;

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_instr, r_pc_out;
  logic        r_valid, r_fault;
  logic [15:0] r_count;
  logic        w_legal, w_do_branch, w_do_capture, w_do_fault;

  // Legality is only consulted on a capture attempt, so a redirect to a bad target
  // or a stalled bad PC does not fault until the next unstalled fetch.
  assign w_legal = (r_pc >= TEXT_BASE) && (r_pc < TEXT_LIMIT) && (r_pc[1:0] == 2'b00);

  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) r_state <= S_BOOT;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:  w_next_state = S_FETCH;
      S_FETCH: if (!i_branch_taken && !i_stall && !w_legal) w_next_state = S_FAULT;
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_BOOT;
    endcase
  end

  always_comb begin
    w_do_branch  = 1'b0;
    w_do_capture = 1'b0;
    w_do_fault   = 1'b0;
    if (r_state == S_FETCH) begin
      w_do_branch  = i_branch_taken;
      w_do_capture = !i_branch_taken && !i_stall && w_legal;
      w_do_fault   = !i_branch_taken && !i_stall && !w_legal;
    end
  end

  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
      r_count  <= '0;
    end else if (w_do_branch) begin
      r_pc    <= i_branch_target;
      r_valid <= 1'b0;
    end else if (w_do_capture) begin
      r_instr  <= i_imem_instr;
      r_pc_out <= r_pc;
      r_valid  <= 1'b1;
      r_pc     <= r_pc + 32'd4;
      r_count  <= r_count + 16'd1;
    end else if (w_do_fault) begin
      r_fault <= 1'b1;
      r_valid <= 1'b0;
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_instr_out   = r_instr;
  assign o_pc_out      = r_pc_out;
  assign o_instr_valid = r_valid;
  assign o_fault       = r_fault;
  assign o_fetch_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the instruction memory returns 0x00221820 + (offset/2),
// so word k of the text segment holds 0x00221820 + 2k.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] imem_addr, imem_instr, branch_target, instr_out, pc_out;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic        instr_valid, fault;
  logic [15:0] fetch_count;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  assign imem_instr = 32'h0022_1820 + ((imem_addr - 32'h0040_0000) >> 1);

  fetch_sequencer dut (
    .i_clock(clock), .i_clear(clear), .o_imem_addr(imem_addr), .i_imem_instr(imem_instr),
    .i_stall(stall), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .o_instr_out(instr_out), .o_pc_out(pc_out), .o_instr_valid(instr_valid),
    .o_fault(fault), .o_fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [15:0] cnt, input logic [31:0] addr,
                         input logic flt);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    chk({tag, ".pc_out"}, pc_out, pc);
    chk({tag, ".instr"}, instr_out, ins);
    chk({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, flt});
  endtask

  initial begin
    branch_target = 32'h0;
    #12;
    chk_out("reset", 0, 32'h0, 32'h0, 0, 32'h0040_0000, 0);
    step(); clear = 1'b0;
    step(); chk_out("boot", 0, 32'h0, 32'h0, 0, 32'h0040_0000, 0);
    step(); chk_out("seq0", 1, 32'h0040_0000, 32'h0022_1820, 1, 32'h0040_0004, 0);
    step(); chk_out("seq1", 1, 32'h0040_0004, 32'h0022_1822, 2, 32'h0040_0008, 0);
    step(); chk_out("seq2", 1, 32'h0040_0008, 32'h0022_1824, 3, 32'h0040_000C, 0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("stall", 1, 32'h0040_0008, 32'h0022_1824, 3, 32'h0040_000C, 0);
    end
    stall = 1'b0;
    step(); chk_out("resume", 1, 32'h0040_000C, 32'h0022_1826, 4, 32'h0040_0010, 0);
    step(); step();
    step(); chk_out("seq6", 1, 32'h0040_0018, 32'h0022_182C, 7, 32'h0040_001C, 0);

    branch_taken = 1'b1; branch_target = 32'h0040_0000;
    step(); chk_out("br_flush", 0, 32'h0040_0018, 32'h0022_182C, 7, 32'h0040_0000, 0);
    branch_taken = 1'b0;
    step(); chk_out("br_tgt", 1, 32'h0040_0000, 32'h0022_1820, 8, 32'h0040_0004, 0);
    step(); chk_out("br_next", 1, 32'h0040_0004, 32'h0022_1822, 9, 32'h0040_0008, 0);

    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0040_0010;
    step(); chk_out("br_stall", 0, 32'h0040_0004, 32'h0022_1822, 9, 32'h0040_0010, 0);
    stall = 1'b0; branch_taken = 1'b0;
    step(); chk_out("br_stall_tgt", 1, 32'h0040_0010, 32'h0022_1828, 10, 32'h0040_0014, 0);

    // asynchronous clear between edges
    #2 clear = 1'b1;
    #1 chk_out("clr_async", 0, 32'h0, 32'h0, 0, 32'h0040_0000, 0);
    step(); clear = 1'b0;
    step(); chk_out("clr_boot", 0, 32'h0, 32'h0, 0, 32'h0040_0000, 0);
    step(); chk_out("clr_first", 1, 32'h0040_0000, 32'h0022_1820, 1, 32'h0040_0004, 0);

    branch_taken = 1'b1; branch_target = 32'h0040_0002;
    step(); chk_out("mis_redir", 0, 32'h0040_0000, 32'h0022_1820, 1, 32'h0040_0002, 0);
    branch_taken = 1'b0;
    step(); chk_out("mis_fault", 0, 32'h0040_0000, 32'h0022_1820, 1, 32'h0040_0002, 1);
    for (int i = 0; i < 10; i++) begin
      stall = i[0]; branch_taken = i[1]; branch_target = 32'h0040_0020;
      step(); chk_out("fault_hold", 0, 32'h0040_0000, 32'h0022_1820, 1, 32'h0040_0002, 1);
    end
    stall = 1'b0; branch_taken = 1'b0;

    // run off the end of the text segment
    clear = 1'b1;
    step(); clear = 1'b0;
    step();
    branch_taken = 1'b1; branch_target = 32'h0040_03F8;
    step(); chk_out("lim_redir", 0, 32'h0, 32'h0, 0, 32'h0040_03F8, 0);
    branch_taken = 1'b0;
    step(); chk_out("lim_3f8", 1, 32'h0040_03F8, 32'h0022_1A1C, 1, 32'h0040_03FC, 0);
    step(); chk_out("lim_3fc", 1, 32'h0040_03FC, 32'h0022_1A1E, 2, 32'h0040_0400, 0);
    stall = 1'b1;
    step(); chk_out("lim_stall", 1, 32'h0040_03FC, 32'h0022_1A1E, 2, 32'h0040_0400, 0);
    stall = 1'b0;
    step(); chk_out("lim_fault", 0, 32'h0040_03FC, 32'h0022_1A1E, 2, 32'h0040_0400, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
